// File: rtl/can_rx_store_ctrl.sv
// CAN RX store controller.
// Takes accepted messages from the bit-stream/acceptance-filter stage, holds them in a
// small FIFO-ordered queue, and paces writes into the RX FIFO. After each write the
// controller waits one settle cycle, so the FIFO full flag is valid before the next
// write is issued. Messages dropped because the queue is full are reported through a
// sticky flag and a saturating counter.
module can_rx_store_ctrl #(
    parameter int unsigned MSG_W     = 128,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                             i_sys_clk,
    input  logic                             i_reset_n,
    input  logic                             i_syn_can_ready,
    input  logic [MSG_W-1:0]                 i_rx_message,
    input  logic                             i_acf_en,
    input  logic                             i_acf_match,
    input  logic                             i_rx_full,
    input  logic                             i_clr_ovr,
    output logic                             o_rx_w_en,
    output logic [MSG_W-1:0]                 o_rx_fifo_w_data,
    output logic                             o_rx_overrun,
    output logic [CNT_W-1:0]                 o_ovr_cnt,
    output logic [$clog2(BUF_DEPTH):0]       o_buf_count,
    output logic                             o_busy
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [MSG_W-1:0] mem_q [BUF_DEPTH];
    logic             w_en_q, w_en_d;
    logic [MSG_W-1:0] w_data_q, w_data_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

    logic             candidate;
    logic             queue_full;
    logic             queue_empty;
    logic             fsm_can_start;
    logic             push;
    logic             pop;
    logic             drop;
    logic [MSG_W-1:0] head_data;

    // Accept/push/pop decisions for this edge
    always_comb begin
        candidate     = i_syn_can_ready & (~i_acf_en | i_acf_match);
        queue_full    = (count_q == OCC_W'(BUF_DEPTH));
        queue_empty   = (count_q == '0);
        // i_rx_full is only looked at in IDLE/SETTLE; WRITE never starts a new write
        fsm_can_start = ((state_q == ST_IDLE) | (state_q == ST_SETTLE)) & ~i_rx_full;
        // A full queue still accepts when the head leaves on the same edge
        push          = candidate & (~queue_full | (fsm_can_start & ~queue_empty));
        // Empty queue bypass: a message pushed this edge can be popped this edge
        pop           = fsm_can_start & (~queue_empty | push);
        drop          = candidate & ~push;
        head_data     = queue_empty ? i_rx_message : mem_q[rd_ptr_q];
    end

    // Write sequencer: one write pulse followed by a settle cycle
    always_comb begin
        state_d  = state_q;
        w_en_d   = 1'b0;
        w_data_d = w_data_q;
        case (state_q)
            ST_IDLE, ST_SETTLE: begin
                if (pop) begin
                    state_d  = ST_WRITE;
                    w_en_d   = 1'b1;
                    w_data_d = head_data;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_SETTLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue pointer and occupancy next-state
    always_comb begin
        count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // Overrun flag and saturating counter; a drop wins over a simultaneous clear
    always_comb begin
        ovr_d     = ovr_q;
        ovr_cnt_d = ovr_cnt_q;
        if (drop) begin
            ovr_d = 1'b1;
            if (i_clr_ovr) begin
                ovr_cnt_d = CNT_W'(1);
            end else if (ovr_cnt_q != CNT_MAX) begin
                ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
            end
        end else if (i_clr_ovr) begin
            ovr_d     = 1'b0;
            ovr_cnt_d = '0;
        end
    end

    // Control and output registers, synchronous active-low reset
    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            w_en_q    <= 1'b0;
            w_data_q  <= '0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            w_en_q    <= w_en_d;
            w_data_q  <= w_data_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    // Queue storage; contents are don't-care while the entry is not occupied
    always_ff @(posedge i_sys_clk) begin
        if (i_reset_n && push) begin
            mem_q[wr_ptr_q] <= i_rx_message;
        end
    end

    assign o_rx_w_en        = w_en_q;
    assign o_rx_fifo_w_data = w_data_q;
    assign o_rx_overrun     = ovr_q;
    assign o_ovr_cnt        = ovr_cnt_q;
    assign o_buf_count      = count_q;
    assign o_busy           = (count_q != '0) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_can_rx_store_ctrl.sv
// Self-checking bench for can_rx_store_ctrl: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a write scoreboard.
module tb_can_rx_store_ctrl;

    localparam int unsigned MSG_W     = 128;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic               clk;
    logic               reset_n;
    logic               syn_can_ready;
    logic [MSG_W-1:0]   rx_message;
    logic               acf_en;
    logic               acf_match;
    logic               rx_full;
    logic               clr_ovr;
    logic               rx_w_en;
    logic [MSG_W-1:0]   rx_fifo_w_data;
    logic               rx_overrun;
    logic [CNT_W-1:0]   ovr_cnt;
    logic [$clog2(BUF_DEPTH):0] buf_count;
    logic               busy;

    can_rx_store_ctrl #(
        .MSG_W     (MSG_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .i_sys_clk        (clk),
        .i_reset_n        (reset_n),
        .i_syn_can_ready  (syn_can_ready),
        .i_rx_message     (rx_message),
        .i_acf_en         (acf_en),
        .i_acf_match      (acf_match),
        .i_rx_full        (rx_full),
        .i_clr_ovr        (clr_ovr),
        .o_rx_w_en        (rx_w_en),
        .o_rx_fifo_w_data (rx_fifo_w_data),
        .o_rx_overrun     (rx_overrun),
        .o_ovr_cnt        (ovr_cnt),
        .o_buf_count      (buf_count),
        .o_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks   = 0;
    int failures = 0;

    // Expected FIFO writes: data and the edge after which o_rx_w_en must be high
    typedef struct {
        logic [MSG_W-1:0] data;
        int               e_no;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [MSG_W-1:0] mq[$];
    int               last_pop = -10;
    logic             m_ovr    = 1'b0;
    int               m_cnt    = 0;
    logic [MSG_W-1:0] m_data   = '0;

    task automatic chk(input string name, input logic [MSG_W-1:0] act,
                       input logic [MSG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: compares every FIFO write against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].e_no < edge_cnt) begin
            checks++;
            failures++;
            $display("FAIL missed_write: expected write after edge %0d did not occur",
                     sb[0].e_no);
            void'(sb.pop_front());
        end
        if (rx_w_en) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write at edge %0d: data %h, none expected",
                         edge_cnt, rx_fifo_w_data);
            end else begin
                e = sb.pop_front();
                if (rx_fifo_w_data !== e.data || e.e_no != edge_cnt) begin
                    failures++;
                    $display("FAIL write_data at edge %0d: got %h expected %h (edge %0d)",
                             edge_cnt, rx_fifo_w_data, e.data, e.e_no);
                end
            end
        end
    end

    // One clock cycle: drive inputs, advance the model, check outputs after the edge
    task automatic step(input bit rst_n_v, input bit rdy, input logic [MSG_W-1:0] msg,
                        input bit en, input bit match, input bit full, input bit clr);
        int e;
        bit cand, can_pop, pop_avail, push;
        reset_n       = rst_n_v;
        syn_can_ready = rdy;
        rx_message    = msg;
        acf_en        = en;
        acf_match     = match;
        rx_full       = full;
        clr_ovr       = clr;
        e = edge_cnt + 1;
        if (!rst_n_v) begin
            mq.delete();
            sb.delete();
            last_pop = -10;
            m_ovr    = 1'b0;
            m_cnt    = 0;
            m_data   = '0;
        end else begin
            cand      = rdy && (!en || match);
            // A write may start at most every second edge and only when not full
            can_pop   = (e - last_pop >= 2) && !full;
            pop_avail = can_pop && (mq.size() > 0);
            push      = cand && ((mq.size() < BUF_DEPTH) || pop_avail);
            if (push) mq.push_back(msg);
            if (can_pop && mq.size() > 0) begin
                m_data   = mq.pop_front();
                last_pop = e;
                sb.push_back('{data: m_data, e_no: e});
            end
            if (cand && !push) begin
                m_ovr = 1'b1;
                m_cnt = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
            end else if (clr) begin
                m_ovr = 1'b0;
                m_cnt = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("w_data", rx_fifo_w_data, m_data);
        chk("overrun", MSG_W'(rx_overrun), MSG_W'(m_ovr));
        chk("ovr_cnt", MSG_W'(ovr_cnt), MSG_W'(m_cnt));
        chk("buf_count", MSG_W'(buf_count), MSG_W'(mq.size()));
        chk("busy", MSG_W'(busy),
            MSG_W'((mq.size() > 0) || (edge_cnt - last_pop <= 1)));
        #1;
    endtask

    function automatic logic [MSG_W-1:0] rnd_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n, input bit full);
        for (int i = 0; i < n; i++) step(1, 0, rnd_msg(), 0, 0, full, 0);
    endtask

    task automatic push_msg(input logic [MSG_W-1:0] m, input bit full);
        step(1, 1, m, 0, 0, full, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MSG_W-1:0] msg_a;
        reset_n = 1'b0; syn_can_ready = 1'b0; rx_message = '0;
        acf_en = 1'b0; acf_match = 1'b0; rx_full = 1'b0; clr_ovr = 1'b0;

        // Reset with ready pulses present
        for (int i = 0; i < 3; i++) step(0, 1, rnd_msg(), 0, 0, 0, 1);
        chk("reset_w_en", MSG_W'(rx_w_en), '0);
        chk("reset_busy", MSG_W'(busy), '0);

        // Single message
        msg_a = 128'hDEADBEEF_00000000_00000000_00000001;
        push_msg(msg_a, 0);
        chk("single_w_en", MSG_W'(rx_w_en), MSG_W'(1));
        chk("single_data", rx_fifo_w_data, msg_a);
        idle(2, 0);
        chk("single_busy_c3", MSG_W'(busy), '0);
        idle(2, 0);

        // Acceptance filter cases
        step(1, 1, rnd_msg(), 1, 0, 0, 0);
        chk("filter_reject", MSG_W'(rx_w_en), '0);
        idle(3, 0);
        chk("filter_no_ovr", MSG_W'(rx_overrun), '0);
        step(1, 1, rnd_msg(), 1, 1, 0, 0);
        idle(3, 0);
        step(1, 1, rnd_msg(), 0, 0, 0, 0);
        idle(3, 0);

        // Backpressure: three pushes into a depth-2 queue while full
        for (int i = 0; i < 3; i++) push_msg(rnd_msg(), 1);
        chk("bp_count", MSG_W'(buf_count), MSG_W'(2));
        chk("bp_ovr", MSG_W'(rx_overrun), MSG_W'(1));
        chk("bp_cnt", MSG_W'(ovr_cnt), MSG_W'(1));
        idle(4, 1);
        idle(6, 0);

        // Full queue with a new message on the popping edge
        step(1, 0, rnd_msg(), 0, 0, 1, 1);
        push_msg(rnd_msg(), 1);
        push_msg(rnd_msg(), 1);
        push_msg(rnd_msg(), 0);
        chk("poppush_no_ovr", MSG_W'(rx_overrun), '0);
        chk("poppush_count", MSG_W'(buf_count), MSG_W'(2));
        idle(8, 0);

        // Counter saturation and clear-with-drop
        step(1, 0, rnd_msg(), 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) push_msg(rnd_msg(), 1);
        chk("sat_cnt", MSG_W'(ovr_cnt), MSG_W'(3));
        step(1, 1, rnd_msg(), 0, 0, 1, 1);
        chk("clr_drop_cnt", MSG_W'(ovr_cnt), MSG_W'(1));
        chk("clr_drop_ovr", MSG_W'(rx_overrun), MSG_W'(1));
        step(1, 0, rnd_msg(), 0, 0, 1, 1);
        chk("clr_cnt", MSG_W'(ovr_cnt), '0);
        chk("clr_ovr", MSG_W'(rx_overrun), '0);
        idle(6, 0);

        // Reset in the middle of a write with a queued message
        push_msg(rnd_msg(), 0);
        push_msg(rnd_msg(), 0);
        step(0, 0, rnd_msg(), 0, 0, 0, 0);
        chk("midreset_w_en", MSG_W'(rx_w_en), '0);
        chk("midreset_count", MSG_W'(buf_count), '0);
        idle(3, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 299) != 0), $urandom_range(0, 1), rnd_msg(),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
        end

        idle(10, 0);
        chk("sb_drain", MSG_W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
